// File: rtl/gpu_cmd_pkg.sv
// Shared constants and types for the command packet assembler.
// Header layout, word/data widths and the assembler state encoding.
package gpu_cmd_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 64;
  localparam int WORDS  = DATA_W / WORD_W;
  localparam int CNT_W  = $clog2(WORDS + 1);

  localparam int HDR_RW_BIT   = WORD_W - 1;
  localparam int HDR_ADDR_MSB = WORD_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    OUT
  } asm_state_t;

endpackage

// File: rtl/cmd_packet_assembler_if.sv
// FIFO read side plus register-file command side of the assembler.
// master: assembler (pops FIFO, drives cmd_*); slave: FIFO/regfile side.
interface cmd_packet_assembler_if;
  import gpu_cmd_pkg::*;

  logic              fifo_rd_en;
  logic [WORD_W-1:0] fifo_rd_data;
  logic              fifo_rd_empty;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              busy;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_empty,
    output cmd_valid,
    input  cmd_ready,
    output cmd_rw,
    output cmd_addr,
    output cmd_data,
    output busy
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_empty,
    input  cmd_valid,
    output cmd_ready,
    input  cmd_rw,
    input  cmd_addr,
    input  cmd_data,
    input  busy
  );

endinterface

// File: rtl/cmd_packet_assembler.sv
// Pops header/data words from a registered-read FIFO into reg packets.
// Ports: clk, rst_n (async low), bus (master: FIFO pop + cmd handshake).
module cmd_packet_assembler
  import gpu_cmd_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  cmd_packet_assembler_if.master bus
);

  asm_state_t        state_q, state_d;
  logic              pend_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  iss_q, iss_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_en;

  logic              hdr_rw;
  logic [ADDR_W-1:0] hdr_addr;
  logic              empty;

  assign empty    = bus.fifo_rd_empty;
  assign hdr_rw   = bus.fifo_rd_data[HDR_RW_BIT];
  assign hdr_addr = bus.fifo_rd_data[HDR_ADDR_MSB -: ADDR_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iss_d   = iss_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          rd_en   = 1'b1;
          state_d = HDR;
        end
      end
      HDR: begin
        // Header word is on fifo_rd_data now; data cleared so reads
        // present zero.
        rw_d   = hdr_rw;
        addr_d = hdr_addr;
        data_d = '0;
        cnt_d  = '0;
        if (hdr_rw) begin
          state_d = OUT;
        end else begin
          state_d = DATA;
          rd_en   = !empty;
          iss_d   = {{(CNT_W-1){1'b0}}, !empty};
        end
      end
      DATA: begin
        if ((iss_q < CNT_W'(WORDS)) && !empty) begin
          rd_en = 1'b1;
          iss_d = iss_q + CNT_W'(1);
        end
        if (pend_q) begin
          data_d = {data_q[DATA_W-WORD_W-1:0], bus.fifo_rd_data};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (bus.cmd_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      iss_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= rd_en;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // IDLE pops on non-empty, so gate with reset to keep rd_en low
  // while the block is held in reset.
  assign bus.fifo_rd_en = rd_en & rst_n;
  assign bus.cmd_valid  = (state_q == OUT);
  assign bus.cmd_rw     = rw_q;
  assign bus.cmd_addr   = addr_q;
  assign bus.cmd_data   = data_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_packet_assembler.sv
// Scoreboard bench for cmd_packet_assembler with a queue-based FIFO.
// Directed latency/stall/reset cases followed by random packets.
module tb_cmd_packet_assembler;
  import gpu_cmd_pkg::*;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                npop;
    int                lat;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_packet_assembler_if bus();

  cmd_packet_assembler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [WORD_W-1:0] fq[$];
  logic              push_en = 1'b0;
  logic              flush = 1'b0;
  logic [WORD_W-1:0] push_data = '0;
  logic              fempty = 1'b1;
  logic [WORD_W-1:0] rdata = '0;
  logic              ready = 1'b0;
  bit                rnd_rdy = 1'b0;

  assign bus.fifo_rd_empty = fempty;
  assign bus.fifo_rd_data  = rdata;
  assign bus.cmd_ready     = ready;

  always @(posedge clk) begin
    if (flush) begin
      fq.delete();
    end else begin
      if (bus.fifo_rd_en && fq.size() > 0)
        rdata <= fq.pop_front();
      if (push_en)
        fq.push_back(push_data);
    end
    fempty <= (fq.size() == 0);
  end

  pkt_t exp_q[$];
  int   vectors = 0;
  int   errs = 0;
  int   tmo = 0;

  function automatic pkt_t model(input logic [WORD_W-1:0] w[$],
                                 input int lat);
    pkt_t p;
    logic [WORD_W-1:0] h;
    h      = w[0];
    p.rw   = h[WORD_W-1];
    p.addr = h[WORD_W-2 -: ADDR_W];
    p.data = '0;
    if (!p.rw)
      for (int i = 1; i <= WORDS; i++)
        p.data = (p.data << WORD_W) | DATA_W'(w[i]);
    p.npop = p.rw ? 1 : WORDS + 1;
    p.lat  = lat;
    return p;
  endfunction

  function automatic void chk(input bit ok, input string nm,
                              input logic [63:0] act,
                              input logic [63:0] req);
    vectors++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, req, $time);
    end
  endfunction

  int                cyc = 0;
  int                npop = 0;
  int                t_hdr = 0;
  int                tmo_seen = 0;
  bit                in_pkt = 1'b0;
  bit                pv = 1'b0;
  pkt_t              e;
  logic              hrw;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hdata;

  always @(negedge clk) begin
    cyc++;
    if (tmo != tmo_seen) begin
      chk(1'b0, "wait_timeout", 64'(tmo), 64'(tmo_seen));
      tmo_seen = tmo;
    end
    if (!rst_n) begin
      chk(bus.fifo_rd_en == 1'b0, "rst_rd_en", 64'(bus.fifo_rd_en), 0);
      chk(bus.cmd_valid == 1'b0, "rst_valid", 64'(bus.cmd_valid), 0);
      chk(bus.cmd_rw == 1'b0, "rst_rw", 64'(bus.cmd_rw), 0);
      chk(bus.cmd_addr == '0, "rst_addr", 64'(bus.cmd_addr), 0);
      chk(bus.cmd_data == '0, "rst_data", bus.cmd_data, 0);
      chk(bus.busy == 1'b0, "rst_busy", 64'(bus.busy), 0);
      in_pkt = 1'b0;
      npop   = 0;
      pv     = 1'b0;
    end else begin
      chk(!(bus.fifo_rd_en && fempty), "pop_on_empty",
          64'(bus.fifo_rd_en), 0);
      chk(bus.busy == in_pkt, "busy", 64'(bus.busy), 64'(in_pkt));
      if (!in_pkt)
        chk(bus.fifo_rd_en == !fempty, "idle_pop",
            64'(bus.fifo_rd_en), 64'(!fempty));
      if (bus.cmd_valid)
        chk(bus.fifo_rd_en == 1'b0, "pop_in_out",
            64'(bus.fifo_rd_en), 0);
      if (bus.cmd_valid && !pv) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pkt", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk(bus.cmd_rw == e.rw, "pkt_rw", 64'(bus.cmd_rw), 64'(e.rw));
          chk(bus.cmd_addr == e.addr, "pkt_addr",
              64'(bus.cmd_addr), 64'(e.addr));
          chk(bus.cmd_data == e.data, "pkt_data", bus.cmd_data, e.data);
          chk(npop == e.npop, "pkt_pops", 64'(npop), 64'(e.npop));
          if (e.lat > 0)
            chk(cyc - t_hdr == e.lat, "latency",
                64'(cyc - t_hdr), 64'(e.lat));
        end
        hrw   = bus.cmd_rw;
        haddr = bus.cmd_addr;
        hdata = bus.cmd_data;
      end else if (bus.cmd_valid) begin
        chk(bus.cmd_rw == hrw, "hold_rw", 64'(bus.cmd_rw), 64'(hrw));
        chk(bus.cmd_addr == haddr, "hold_addr",
            64'(bus.cmd_addr), 64'(haddr));
        chk(bus.cmd_data == hdata, "hold_data", bus.cmd_data, hdata);
      end
      if (bus.fifo_rd_en) begin
        if (npop == 0) t_hdr = cyc;
        npop++;
      end
      if (bus.fifo_rd_en && !in_pkt) in_pkt = 1'b1;
      if (bus.cmd_valid && ready) begin
        in_pkt = 1'b0;
        npop   = 0;
      end
      pv = bus.cmd_valid && !ready;
    end
  end

  task automatic step(input bit en, input logic [WORD_W-1:0] d);
    @(posedge clk);
    #1;
    push_en   = en;
    push_data = d;
    if (rnd_rdy) ready = 1'($urandom_range(1, 0));
  endtask

  task automatic send(input logic [WORD_W-1:0] w[$], input int gmin,
                      input int gmax, input int lat);
    exp_q.push_back(model(w, lat));
    foreach (w[i]) begin
      repeat ($urandom_range(gmax, gmin)) step(1'b0, '0);
      step(1'b1, w[i]);
    end
  endtask

  task automatic wait_done(input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step(1'b0, '0);
      if (exp_q.size() == 0 && !bus.busy && fempty) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tmo++;
  endtask

  function automatic logic [WORD_W-1:0] mk_hdr(input logic rw);
    logic [ADDR_W-1:0] a;
    logic [WORD_W-ADDR_W-2:0] r;
    a = ADDR_W'($urandom);
    r = (WORD_W-ADDR_W-1)'($urandom);
    return {rw, a, r};
  endfunction

  logic [WORD_W-1:0] wq[$];

  initial begin
    // Reset with a write packet already waiting in the FIFO.
    wq = {};
    wq.push_back(16'h0000);
    wq.push_back(16'h1122);
    wq.push_back(16'h3344);
    wq.push_back(16'h5566);
    wq.push_back(16'h7788);
    send(wq, 0, 0, 6);
    step(1'b0, '0);
    step(1'b0, '0);
    rst_n = 1'b1;
    ready = 1'b1;
    wait_done(50);

    // Single read packet.
    wq = {};
    wq.push_back(16'h8500);
    send(wq, 0, 0, 2);
    wait_done(50);

    // Write with data words trickling in every third cycle.
    wq = {};
    wq.push_back(mk_hdr(1'b0));
    for (int i = 0; i < WORDS; i++) wq.push_back(WORD_W'($urandom));
    send(wq, 2, 2, 0);
    wait_done(100);

    // Two reads back to back while the register file stalls.
    ready = 1'b0;
    wq = {};
    wq.push_back(mk_hdr(1'b1));
    send(wq, 0, 0, 2);
    wq = {};
    wq.push_back(mk_hdr(1'b1));
    send(wq, 0, 0, 2);
    repeat (6) step(1'b0, '0);
    ready = 1'b1;
    wait_done(50);

    // Reset after two data words of a write have been popped.
    step(1'b1, mk_hdr(1'b0));
    step(1'b1, WORD_W'($urandom));
    step(1'b1, WORD_W'($urandom));
    repeat (4) step(1'b0, '0);
    rst_n = 1'b0;
    flush = 1'b1;
    repeat (2) step(1'b0, '0);
    rst_n = 1'b1;
    flush = 1'b0;
    wq = {};
    wq.push_back(mk_hdr(1'b0));
    for (int i = 0; i < WORDS; i++) wq.push_back(WORD_W'($urandom));
    send(wq, 0, 0, 6);
    wait_done(50);

    // Random packets, gaps and back-pressure.
    rnd_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      wq = {};
      wq.push_back(mk_hdr(1'($urandom_range(1, 0))));
      if (!wq[0][WORD_W-1])
        for (int i = 0; i < WORDS; i++) wq.push_back(WORD_W'($urandom));
      send(wq, 0, 2, 0);
    end
    rnd_rdy = 1'b0;
    ready = 1'b1;
    wait_done(2000);

    if (exp_q.size() != 0) tmo++;
    repeat (3) step(1'b0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_packet_assembler.md
Name: cmd_packet_assembler

Overview:
- Sits directly downstream of the command sync FIFO.
- Pops 16-bit words from the FIFO's registered-read interface (data arrives 1 cycle after rd_en) and assembles them into register-access packets: one header word, plus data words for writes.
- Presents each complete packet to the register file over a valid/ready handshake.
- Never pops beyond the end of the current packet.

Parameters:
- WORD_W, 16, FIFO word width; must equal the FIFO WIDTH.
- ADDR_W, 7, register address width; ADDR_W+1 <= WORD_W.
- DATA_W, 64, register data width; integer multiple of WORD_W.
- WORDS, DATA_W/WORD_W (4), derived: data words per write packet.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fifo_rd_en  out  1  pop request to FIFO.
- fifo_rd_data  in  WORD_W  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty flag.
- cmd_valid  out  1  packet available.
- cmd_ready  in  1  register file accepts packet.
- cmd_rw  out  1  1 = read request, 0 = write.
- cmd_addr  out  ADDR_W  register address.
- cmd_data  out  DATA_W  write data; 0 for reads.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock, clk. Reset rst_n is asynchronous assert, active-low. Reset forces IDLE and clears all outputs: fifo_rd_en=0, cmd_valid=0, cmd_rw=0, cmd_addr=0, cmd_data=0, busy=0.
- Header format: bit WORD_W-1 = rw; bits [WORD_W-2 -: ADDR_W] = addr; remaining low bits reserved and ignored.
- Data words: arrive MSB-first. The first data word fills cmd_data[DATA_W-1 -: WORD_W].
- fifo_rd_en is combinational from state, the outstanding-read flag and fifo_rd_empty. It is never high while fifo_rd_empty=1.
- Outstanding-read flag: a register equal to the previous cycle's fifo_rd_en. When set, fifo_rd_data is captured this cycle.
- IDLE: if !empty, assert rd_en and go to HDR.
- HDR (header arriving):
  - Decode fifo_rd_data combinationally and latch rw/addr.
  - rw=1: go to OUT. No further pops.
  - rw=0: clear the word counter, go to DATA, and assert rd_en this same cycle if !empty.
- DATA:
  - On each captured word, shift it into cmd_data and increment the counter.
  - Assert rd_en only while issued reads < WORDS and !empty.
  - When the WORDS-th word is captured, go to OUT.
  - An empty FIFO stalls with no pops and no state loss.
- OUT:
  - cmd_valid=1; outputs held stable; no pops.
  - When cmd_valid && cmd_ready, go to IDLE; cmd_valid falls the next cycle.
  - The next header pop issues from IDLE, so there is a 1-cycle bubble between packets.
- Latency, with t = the cycle of the header rd_en on a non-empty FIFO:
  - Read packet: cmd_valid high at t+2.
  - Write packet: data rd_en at t+1..t+4, cmd_valid high at t+6.
- cmd_ready high while not in OUT has no effect.
- Reset mid-packet: already-popped words are discarded. The FIFO is reset together with this block.
- Word counter: $clog2(WORDS+1) bits, no wrap.

Decomposition:
- Shared package gpu_cmd_pkg holds:
  - ADDR_W, DATA_W, WORD_W constants.
  - Header field positions (HDR_RW_BIT, HDR_ADDR_MSB).
  - Typedef asm_state_t {IDLE, HDR, DATA, OUT}.
- No sub-module: the FSM plus data shift register is a single module.

Test Plan:
- Reset with FIFO holding words → all outputs 0, no rd_en during reset, busy=0.
- Preload 0x0000,0x1122,0x3344,0x5566,0x7788 → five consecutive pops (t..t+4), cmd_valid at t+6, rw=0, addr=0x00, data=0x1122334455667788.
- Preload 0x8500 with cmd_ready=1 → cmd_valid at t+2, rw=1, addr=0x05, data=0, exactly one pop.
- Write packet whose data words are pushed one every 3 cycles → rd_en never high while empty, final data correct, cmd_valid only after the 4th data word.
- Two back-to-back read packets with cmd_ready=0 for 5 cycles → first packet held stable, no second pop until the handshake, second header popped the cycle after IDLE is re-entered.
- Assert rst_n low after 2 data words of a write → IDLE next edge, cmd_valid=0. After release, a fresh packet assembles correctly.
